gray_seq_monitor: RTL

Receive-side companion to the 3-bit Gray up-counter. It samples a Gray-coded count bus, decodes it to binary, and checks that every sampled code is either unchanged or the legal forward successor. It reports wrap-around (sticky `Overflow` plus a saturating wrap counter) and latches a sticky `Error` on any illegal step. It sits on the consumer side of any Gray-coded counter bus in the design.

---
 rtl/gray_pkg.sv | 31 +++
 rtl/gray_to_bin.sv | 16 +
 rtl/gray_seq_monitor.sv | 91 +++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: monitor state encoding and width-generic
// Gray/binary conversions used by producers, monitors and benches.
package gray_pkg;

  localparam int MAX_W = 8;

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} mon_state_e;

  function automatic logic [MAX_W-1:0] width_mask(input int width);
    logic [MAX_W-1:0] ones;
    ones = '1;
    return ones >> (MAX_W - width);
  endfunction

  // Binary is the prefix XOR from the MSB, i.e. the XOR of every right shift of g.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g, input int width);
    logic [MAX_W-1:0] gm;
    logic [MAX_W-1:0] b;
    gm = g & width_mask(width);
    b  = gm;
    for (int s = 1; s < MAX_W; s++) b = b ^ (gm >> s);
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b, input int width);
    logic [MAX_W-1:0] bm;
    bm = b & width_mask(width);
    return bm ^ (bm >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder of parameterised width.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic [MAX_W-1:0] bin_full;

  assign bin_full = gray2bin(MAX_W'(gray), WIDTH);
  assign bin      = bin_full[WIDTH-1:0];

endmodule

// File: rtl/gray_seq_monitor.sv
// Checks that a sampled Gray count only holds or steps forward by one,
// counting legal wraps and latching a sticky error on any illegal step.
module gray_seq_monitor
  import gray_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid,
  input  logic [WIDTH-1:0]  GrayIn,
  output logic [WIDTH-1:0]  Binary,
  output logic              Locked,
  output logic              Error,
  output logic              Overflow,
  output logic              Wrap,
  output logic [WRAP_W-1:0] WrapCount
);

  mon_state_e        state_q, state_d;
  logic [WIDTH-1:0]  binary_d;
  logic              error_d, overflow_d, wrap_d;
  logic [WRAP_W-1:0] wrap_count_d;
  logic [WIDTH-1:0]  sample_bin;
  logic [WIDTH-1:0]  successor;

  gray_to_bin #(.WIDTH(WIDTH)) u_dec (
    .gray (GrayIn),
    .bin  (sample_bin)
  );

  assign successor = Binary + WIDTH'(1);

  // NOTE: every output is assigned a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    binary_d     = Binary;
    error_d      = Error;
    overflow_d   = Overflow;
    wrap_d       = 1'b0;
    wrap_count_d = WrapCount;
    unique case (state_q)
      IDLE: begin
        if (Valid) begin
          binary_d = sample_bin;
          state_d  = TRACK;
        end
      end
      TRACK: begin
        if (Valid && sample_bin != Binary) begin
          if (sample_bin == successor) begin
            binary_d = sample_bin;
            if (Binary == '1) begin
              wrap_d     = 1'b1;
              overflow_d = 1'b1;
              if (WrapCount != '1) wrap_count_d = WrapCount + WRAP_W'(1);
            end
          end else begin
            error_d = 1'b1;
            state_d = FAULT;
          end
        end
      end
      FAULT: ;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      Binary    <= '0;
      Locked    <= 1'b0;
      Error     <= 1'b0;
      Overflow  <= 1'b0;
      Wrap      <= 1'b0;
      WrapCount <= '0;
    end else begin
      state_q   <= state_d;
      Binary    <= binary_d;
      Locked    <= (state_d == TRACK);
      Error     <= error_d;
      Overflow  <= overflow_d;
      Wrap      <= wrap_d;
      WrapCount <= wrap_count_d;
    end
  end

endmodule
